// File: rtl/cache_data_array_if.sv
// CPU/refill port bundle for cache_data_array: the master side drives requests, the slave side is the array.
interface cache_data_array_if #(
   parameter int DATA_W = 32,
   parameter int LINES  = 32,
   parameter int BLOCKS = 4
);
   localparam int LINE_W = $clog2(LINES);
   localparam int BLK_W  = $clog2(BLOCKS);

   logic                cpu_rd_en;
   logic                cpu_wr_en;
   logic [LINE_W-1:0]   cpu_line;
   logic [BLK_W-1:0]    cpu_block;
   logic [DATA_W-1:0]   cpu_wdata;
   logic [DATA_W/8-1:0] cpu_be;
   logic [DATA_W-1:0]   rd_data;
   logic                rd_valid;
   logic                refill_start;
   logic [LINE_W-1:0]   refill_line;
   logic                mem_valid;
   logic [DATA_W-1:0]   mem_data;
   logic                refill_busy;
   logic [BLK_W-1:0]    refill_block;
   logic                refill_done;

   modport master (
      output cpu_rd_en, cpu_wr_en, cpu_line, cpu_block, cpu_wdata, cpu_be,
      output refill_start, refill_line, mem_valid, mem_data,
      input  rd_data, rd_valid, refill_busy, refill_block, refill_done
   );

   modport slave (
      input  cpu_rd_en, cpu_wr_en, cpu_line, cpu_block, cpu_wdata, cpu_be,
      input  refill_start, refill_line, mem_valid, mem_data,
      output rd_data, rd_valid, refill_busy, refill_block, refill_done
   );
endinterface

// File: rtl/cache_data_array.sv
// Cache data store with a 1-cycle CPU read port, CPU write port and a line-refill FSM.
// Define CACHE_BYTE_WRITE_EN to make CPU writes honour cpu_be; otherwise CPU writes are full-word.
module cache_data_array #(
   parameter int DATA_W = 32,
   parameter int LINES  = 32,
   parameter int BLOCKS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   cache_data_array_if.slave bus
);
   localparam int LINE_W = $clog2(LINES);
   localparam int BLK_W  = $clog2(BLOCKS);
   localparam int ADDR_W = LINE_W + BLK_W;
   localparam int NBYTES = DATA_W / 8;
   localparam int DEPTH  = LINES * BLOCKS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [BLK_W-1:0]    cnt;
   logic [BLK_W-1:0]    cnt_nxt;
   logic [LINE_W-1:0]   fill_line;
   logic [LINE_W-1:0]   fill_line_nxt;
   logic                fill_we;
   logic                cpu_we;
   logic [ADDR_W-1:0]   cpu_addr;
   logic [ADDR_W-1:0]   fill_addr;
   logic [NBYTES-1:0]   wr_be;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   rd_data_p1;
   logic                vld_p1;

`ifdef CACHE_BYTE_WRITE_EN
   assign wr_be = bus.cpu_be;
`else
   logic unused_be;
   assign unused_be = ^bus.cpu_be;
   assign wr_be     = '1;
`endif

   assign cpu_addr  = {bus.cpu_line, bus.cpu_block};
   assign fill_addr = {fill_line, cnt};
   // CPU writes only land while no refill owns the array (IDLE).
   assign cpu_we    = bus.cpu_wr_en && (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         fill_line <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         fill_line <= fill_line_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      fill_line_nxt = fill_line;
      fill_we       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.refill_start) begin
               fill_line_nxt = bus.refill_line;
               cnt_nxt       = '0;
               state_nxt     = FILL;
            end
         end
         FILL: begin
            if (bus.mem_valid) begin
               fill_we = 1'b1;
               cnt_nxt = cnt + 1'b1;
               if (cnt == BLK_W'(BLOCKS - 1)) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.refill_busy  = (state != IDLE);
   assign bus.refill_block = cnt;
   assign bus.refill_done  = (state == DONE);

   // Storage write port: refills are full-word, CPU writes are byte-gated. Contents are never reset.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         mem[fill_addr] <= bus.mem_data;
      end else if (cpu_we) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (wr_be[b]) begin
               mem[cpu_addr][b*8 +: 8] <= bus.cpu_wdata[b*8 +: 8];
            end
         end
      end
   end

   // Read stage p1: old contents are sampled, so a same-cycle write is not visible yet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_p1 <= '0;
         vld_p1     <= 1'b0;
      end else begin
         vld_p1 <= bus.cpu_rd_en;
         if (bus.cpu_rd_en) begin
            rd_data_p1 <= mem[cpu_addr];
         end
      end
   end

   assign bus.rd_data  = rd_data_p1;
   assign bus.rd_valid = vld_p1;

endmodule

// File: tb/tb_cache_data_array.sv
// Randomised and directed bench for cache_data_array against an array-based storage model.
module tb_cache_data_array;
   localparam int DATA_W = 32;
   localparam int LINES  = 32;
   localparam int BLOCKS = 4;
   localparam int LINE_W = $clog2(LINES);
   localparam int BLK_W  = $clog2(BLOCKS);
   localparam int NB     = DATA_W / 8;
   localparam int DEPTH  = LINES * BLOCKS;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cache_data_array_if #(.DATA_W(DATA_W), .LINES(LINES), .BLOCKS(BLOCKS)) bus ();

   cache_data_array #(.DATA_W(DATA_W), .LINES(LINES), .BLOCKS(BLOCKS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [DATA_W-1:0] ref_mem [DEPTH];
   logic [NB-1:0]     ref_kb  [DEPTH];

   int gap_pat [7] = '{1, 0, 0, 1, 1, 0, 1};
   int gap_blk [7] = '{0, 1, 1, 1, 2, 3, 3};

   function automatic int addr_of(input int line, input int blk);
      return line * BLOCKS + blk;
   endfunction

   function automatic void model_cpu_write(input int a, input logic [DATA_W-1:0] d,
                                           input logic [NB-1:0] be);
`ifdef CACHE_BYTE_WRITE_EN
      for (int b = 0; b < NB; b++) begin
         if (be[b]) begin
            ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
            ref_kb[a][b]         = 1'b1;
         end
      end
`else
      if (be == be) begin
         ref_mem[a] = d;
         ref_kb[a]  = '1;
      end
`endif
   endfunction

   function automatic void model_fill_write(input int a, input logic [DATA_W-1:0] d);
      ref_mem[a] = d;
      ref_kb[a]  = '1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cpu_rd_en    = 1'b0;
      bus.cpu_wr_en    = 1'b0;
      bus.cpu_line     = '0;
      bus.cpu_block    = '0;
      bus.cpu_wdata    = '0;
      bus.cpu_be       = '0;
      bus.refill_start = 1'b0;
      bus.refill_line  = '0;
      bus.mem_valid    = 1'b0;
      bus.mem_data     = '0;
   endtask

   task automatic cpu_write(input int line, input int blk, input logic [DATA_W-1:0] d,
                            input logic [NB-1:0] be);
      bus.cpu_wr_en = 1'b1;
      bus.cpu_line  = LINE_W'(line);
      bus.cpu_block = BLK_W'(blk);
      bus.cpu_wdata = d;
      bus.cpu_be    = be;
      tick();
      bus.cpu_wr_en = 1'b0;
   endtask

   task automatic cpu_read(input int line, input int blk, output logic [DATA_W-1:0] d,
                           output logic v);
      bus.cpu_rd_en = 1'b1;
      bus.cpu_line  = LINE_W'(line);
      bus.cpu_block = BLK_W'(blk);
      tick();
      d = bus.rd_data;
      v = bus.rd_valid;
      bus.cpu_rd_en = 1'b0;
   endtask

   task automatic start_refill(input int line);
      bus.refill_start = 1'b1;
      bus.refill_line  = LINE_W'(line);
      tick();
      bus.refill_start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (3) tick();
      n_vec++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %0b want 0", bus.rd_valid); end
      n_vec++; if (bus.rd_data !== '0) begin n_err++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
      n_vec++; if (bus.refill_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", bus.refill_busy); end
      n_vec++; if (bus.refill_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", bus.refill_done); end
      n_vec++; if (bus.refill_block !== '0) begin n_err++; $display("FAIL reset_block: got %0d want 0", bus.refill_block); end
      rst_n = 1'b1;
      tick();
      n_vec++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_rd_valid: got %0b want 0", bus.rd_valid); end
   endtask

   task automatic test_refill_basic();
      logic [DATA_W-1:0] w [BLOCKS];
      logic [DATA_W-1:0] d;
      int done_cnt;
      done_cnt = 0;
      for (int i = 0; i < BLOCKS; i++) w[i] = $urandom;
      start_refill(5);
      n_vec++; if (bus.refill_busy !== 1'b1) begin n_err++; $display("FAIL fill_busy: got %0b want 1", bus.refill_busy); end
      n_vec++; if (bus.refill_block !== '0) begin n_err++; $display("FAIL fill_block0: got %0d want 0", bus.refill_block); end
      for (int i = 0; i < BLOCKS; i++) begin
         bus.mem_valid = 1'b1;
         bus.mem_data  = w[i];
         tick();
         model_fill_write(addr_of(5, i), w[i]);
         if (bus.refill_done === 1'b1) done_cnt++;
         n_vec++;
         if (bus.refill_done !== (i == BLOCKS - 1)) begin
            n_err++; $display("FAIL fill_done_word%0d: got %0b want %0b", i, bus.refill_done, (i == BLOCKS - 1));
         end
      end
      bus.mem_valid = 1'b0;
      tick();
      if (bus.refill_done === 1'b1) done_cnt++;
      n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL fill_done_count: got %0d want 1", done_cnt); end
      n_vec++; if (bus.refill_busy !== 1'b0) begin n_err++; $display("FAIL fill_idle_busy: got %0b want 0", bus.refill_busy); end
      for (int i = 0; i < BLOCKS; i++) begin
         bus.cpu_rd_en = 1'b1;
         bus.cpu_line  = LINE_W'(5);
         bus.cpu_block = BLK_W'(i);
         tick();
         n_vec++; if (bus.rd_valid !== 1'b1) begin n_err++; $display("FAIL b2b_rd_valid%0d: got %0b want 1", i, bus.rd_valid); end
         n_vec++; if (bus.rd_data !== w[i]) begin n_err++; $display("FAIL b2b_rd_data%0d: got %h want %h", i, bus.rd_data, w[i]); end
      end
      bus.cpu_rd_en = 1'b0;
      tick();
      n_vec++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid_drop: got %0b want 0", bus.rd_valid); end
      n_vec++; if (bus.rd_data !== w[BLOCKS-1]) begin n_err++; $display("FAIL rd_data_hold: got %h want %h", bus.rd_data, w[BLOCKS-1]); end
      cpu_read(5, 0, d, done_cnt[0]);
      n_vec++; if (d !== w[0]) begin n_err++; $display("FAIL refill_read0: got %h want %h", d, w[0]); end
   endtask

   task automatic test_refill_gaps();
      int k;
      logic [DATA_W-1:0] d;
      logic v;
      k = 0;
      start_refill(9);
      for (int i = 0; i < 7; i++) begin
         n_vec++;
         if (bus.refill_block !== BLK_W'(gap_blk[i])) begin
            n_err++; $display("FAIL gap_block%0d: got %0d want %0d", i, bus.refill_block, gap_blk[i]);
         end
         bus.mem_valid = (gap_pat[i] != 0);
         bus.mem_data  = $urandom;
         if (gap_pat[i] != 0) begin
            model_fill_write(addr_of(9, k), bus.mem_data);
            k++;
         end
         tick();
         n_vec++;
         if (bus.refill_done !== (i == 6)) begin
            n_err++; $display("FAIL gap_done%0d: got %0b want %0b", i, bus.refill_done, (i == 6));
         end
      end
      bus.mem_valid = 1'b0;
      tick();
      n_vec++; if (bus.refill_busy !== 1'b0) begin n_err++; $display("FAIL gap_busy_end: got %0b want 0", bus.refill_busy); end
      cpu_read(9, 3, d, v);
      n_vec++; if (d !== ref_mem[addr_of(9, 3)]) begin n_err++; $display("FAIL gap_read3: got %h want %h", d, ref_mem[addr_of(9, 3)]); end
   endtask

   task automatic test_busy_write();
      logic [DATA_W-1:0] d;
      logic v;
      cpu_write(3, 2, 32'h0BADF00D, '1);
      model_cpu_write(addr_of(3, 2), 32'h0BADF00D, '1);
      start_refill(10);
      bus.cpu_wr_en = 1'b1;
      bus.cpu_line  = LINE_W'(3);
      bus.cpu_block = BLK_W'(2);
      bus.cpu_wdata = 32'hDEADBEEF;
      bus.cpu_be    = '1;
      for (int i = 0; i < BLOCKS; i++) begin
         bus.mem_valid = 1'b1;
         bus.mem_data  = $urandom;
         model_fill_write(addr_of(10, i), bus.mem_data);
         tick();
      end
      bus.mem_valid = 1'b0;
      tick();
      bus.cpu_wr_en = 1'b0;
      cpu_read(3, 2, d, v);
      n_vec++; if (d !== 32'h0BADF00D) begin n_err++; $display("FAIL busy_write_dropped: got %h want 0badf00d", d); end
      cpu_read(10, 1, d, v);
      n_vec++; if (d !== ref_mem[addr_of(10, 1)]) begin n_err++; $display("FAIL busy_refill_word: got %h want %h", d, ref_mem[addr_of(10, 1)]); end
      cpu_write(3, 2, 32'hDEADBEEF, '1);
      model_cpu_write(addr_of(3, 2), 32'hDEADBEEF, '1);
      cpu_read(3, 2, d, v);
      n_vec++; if (d !== 32'hDEADBEEF) begin n_err++; $display("FAIL idle_write: got %h want deadbeef", d); end
   endtask

   task automatic test_byte_write();
      logic [DATA_W-1:0] d;
      logic v;
      logic [DATA_W-1:0] exp1;
      logic [DATA_W-1:0] exp2;
`ifdef CACHE_BYTE_WRITE_EN
      exp1 = 32'h11BB33DD;
      exp2 = 32'h11BB33DD;
`else
      exp1 = 32'hAABBCCDD;
      exp2 = 32'hFFFFFFFF;
`endif
      cpu_write(4, 1, 32'h11223344, 4'b1111);
      model_cpu_write(addr_of(4, 1), 32'h11223344, 4'b1111);
      cpu_write(4, 1, 32'hAABBCCDD, 4'b0101);
      model_cpu_write(addr_of(4, 1), 32'hAABBCCDD, 4'b0101);
      cpu_read(4, 1, d, v);
      n_vec++; if (d !== exp1) begin n_err++; $display("FAIL byte_merge: got %h want %h", d, exp1); end
      cpu_write(4, 1, 32'hFFFFFFFF, 4'b0000);
      model_cpu_write(addr_of(4, 1), 32'hFFFFFFFF, 4'b0000);
      cpu_read(4, 1, d, v);
      n_vec++; if (d !== exp2) begin n_err++; $display("FAIL byte_zero_be: got %h want %h", d, exp2); end
   endtask

   task automatic test_refill_and_write();
      logic [DATA_W-1:0] d;
      logic [DATA_W-1:0] wd;
      logic v;
      wd = $urandom;
      bus.refill_start = 1'b1;
      bus.refill_line  = LINE_W'(11);
      bus.cpu_wr_en    = 1'b1;
      bus.cpu_line     = LINE_W'(6);
      bus.cpu_block    = BLK_W'(3);
      bus.cpu_wdata    = wd;
      bus.cpu_be       = '1;
      tick();
      model_cpu_write(addr_of(6, 3), wd, '1);
      bus.refill_start = 1'b0;
      bus.cpu_wr_en    = 1'b0;
      n_vec++; if (bus.refill_busy !== 1'b1) begin n_err++; $display("FAIL combo_busy: got %0b want 1", bus.refill_busy); end
      for (int i = 0; i < BLOCKS; i++) begin
         bus.mem_valid = 1'b1;
         bus.mem_data  = $urandom;
         model_fill_write(addr_of(11, i), bus.mem_data);
         tick();
      end
      bus.mem_valid = 1'b0;
      tick();
      cpu_read(6, 3, d, v);
      n_vec++; if (d !== wd) begin n_err++; $display("FAIL combo_cpu_word: got %h want %h", d, wd); end
      cpu_read(11, 2, d, v);
      n_vec++; if (d !== ref_mem[addr_of(11, 2)]) begin n_err++; $display("FAIL combo_fill_word: got %h want %h", d, ref_mem[addr_of(11, 2)]); end
   endtask

   task automatic test_reset_mid_fill();
      logic [DATA_W-1:0] d;
      logic v;
      int done_seen;
      done_seen = 0;
      start_refill(12);
      for (int i = 0; i < 2; i++) begin
         bus.mem_valid = 1'b1;
         bus.mem_data  = $urandom;
         model_fill_write(addr_of(12, i), bus.mem_data);
         tick();
      end
      bus.mem_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_vec++; if (bus.refill_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %0b want 0", bus.refill_busy); end
      n_vec++; if (bus.refill_block !== '0) begin n_err++; $display("FAIL abort_block: got %0d want 0", bus.refill_block); end
      n_vec++; if (bus.rd_data !== '0) begin n_err++; $display("FAIL abort_rd_data: got %h want 0", bus.rd_data); end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (bus.refill_done !== 1'b0) done_seen++;
         tick();
      end
      n_vec++; if (done_seen != 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses want 0", done_seen); end
      cpu_read(12, 0, d, v);
      n_vec++; if (d !== ref_mem[addr_of(12, 0)]) begin n_err++; $display("FAIL abort_word0: got %h want %h", d, ref_mem[addr_of(12, 0)]); end
      cpu_read(12, 1, d, v);
      n_vec++; if (d !== ref_mem[addr_of(12, 1)]) begin n_err++; $display("FAIL abort_word1: got %h want %h", d, ref_mem[addr_of(12, 1)]); end
   endtask

   task automatic test_rd_wr_collision();
      logic [DATA_W-1:0] d;
      logic v;
      cpu_write(7, 1, 32'h9, '1);
      model_cpu_write(addr_of(7, 1), 32'h9, '1);
      bus.cpu_rd_en = 1'b1;
      bus.cpu_wr_en = 1'b1;
      bus.cpu_line  = LINE_W'(7);
      bus.cpu_block = BLK_W'(1);
      bus.cpu_wdata = 32'h5;
      bus.cpu_be    = '1;
      tick();
      model_cpu_write(addr_of(7, 1), 32'h5, '1);
      bus.cpu_rd_en = 1'b0;
      bus.cpu_wr_en = 1'b0;
      n_vec++; if (bus.rd_valid !== 1'b1) begin n_err++; $display("FAIL coll_valid: got %0b want 1", bus.rd_valid); end
      n_vec++; if (bus.rd_data !== 32'h9) begin n_err++; $display("FAIL coll_old_data: got %h want 9", bus.rd_data); end
      cpu_read(7, 1, d, v);
      n_vec++; if (d !== 32'h5) begin n_err++; $display("FAIL coll_new_data: got %h want 5", d); end
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] exp_rd;
      bit exp_known;
      exp_rd    = '0;
      exp_known = 1'b0;
      for (int it = 0; it < 400; it++) begin
         bit rd;
         bit wr;
         int ra;
         int wa;
         logic [DATA_W-1:0] wd;
         logic [NB-1:0] be;
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         ra = addr_of($urandom_range(0, 3), $urandom_range(0, BLOCKS - 1));
         wa = wr && $urandom_range(0, 1) ? ra : addr_of($urandom_range(0, 3), $urandom_range(0, BLOCKS - 1));
         if (rd) wa = ra;
         wd = $urandom;
         be = NB'($urandom_range(0, (1 << NB) - 1));
         if (rd) begin
            exp_rd    = ref_mem[ra];
            exp_known = (ref_kb[ra] == '1);
         end
         bus.cpu_rd_en = rd;
         bus.cpu_wr_en = wr;
         bus.cpu_line  = LINE_W'(rd ? ra / BLOCKS : wa / BLOCKS);
         bus.cpu_block = BLK_W'(rd ? ra % BLOCKS : wa % BLOCKS);
         bus.cpu_wdata = wd;
         bus.cpu_be    = be;
         if (wr) model_cpu_write(wa, wd, be);
         tick();
         n_vec++; if (bus.rd_valid !== rd) begin n_err++; $display("FAIL rand_valid%0d: got %0b want %0b", it, bus.rd_valid, rd); end
         if (exp_known) begin
            n_vec++; if (bus.rd_data !== exp_rd) begin n_err++; $display("FAIL rand_data%0d: got %h want %h", it, bus.rd_data, exp_rd); end
         end
      end
      idle_inputs();
      for (int r = 0; r < 4; r++) begin
         int line;
         int k;
         int guard;
         line  = $urandom_range(0, LINES - 1);
         k     = 0;
         guard = 0;
         start_refill(line);
         while (k < BLOCKS && guard < 200) begin
            bit v;
            bit rd;
            int ra;
            bit done_exp;
            guard++;
            v  = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            ra = addr_of($urandom_range(0, 1) ? line : $urandom_range(0, 3), $urandom_range(0, BLOCKS - 1));
            exp_rd    = ref_mem[ra];
            exp_known = (ref_kb[ra] == '1);
            bus.mem_valid = v;
            bus.mem_data  = $urandom;
            bus.cpu_rd_en = rd;
            bus.cpu_wr_en = 1'($urandom_range(0, 1));
            bus.cpu_wdata = $urandom;
            bus.cpu_be    = '1;
            bus.cpu_line  = LINE_W'(ra / BLOCKS);
            bus.cpu_block = BLK_W'(ra % BLOCKS);
            if (v) begin
               model_fill_write(addr_of(line, k), bus.mem_data);
               k++;
            end
            done_exp = v && (k == BLOCKS);
            tick();
            n_vec++; if (bus.refill_busy !== 1'b1) begin n_err++; $display("FAIL rfill_busy%0d: got %0b want 1", r, bus.refill_busy); end
            n_vec++; if (bus.refill_done !== done_exp) begin n_err++; $display("FAIL rfill_done%0d: got %0b want %0b", r, bus.refill_done, done_exp); end
            if (rd && exp_known) begin
               n_vec++; if (bus.rd_data !== exp_rd) begin n_err++; $display("FAIL rfill_rd%0d: got %h want %h", r, bus.rd_data, exp_rd); end
            end
         end
         n_vec++; if (k != BLOCKS) begin n_err++; $display("FAIL rfill_budget%0d: got %0d words want %0d", r, k, BLOCKS); end
         idle_inputs();
         tick();
         n_vec++; if (bus.refill_busy !== 1'b0) begin n_err++; $display("FAIL rfill_end_busy%0d: got %0b want 0", r, bus.refill_busy); end
         n_vec++; if (bus.refill_done !== 1'b0) begin n_err++; $display("FAIL rfill_end_done%0d: got %0b want 0", r, bus.refill_done); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ref_mem[i] = 'x;
         ref_kb[i]  = '0;
      end
      test_reset();
      test_refill_basic();
      test_refill_gaps();
      test_busy_write();
      test_byte_write();
      test_refill_and_write();
      test_reset_mid_fill();
      test_rd_wr_collision();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/cache_data_array.md
CACHE_DATA_ARRAY -- requirements
Module: cache_data_array

Interface
REQ-001 Parameter DATA_W, default 32: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter LINES, default 32: number of cache lines; SHALL be a power of two, at least 2.
REQ-003 Parameter BLOCKS, default 4: words per line; SHALL be a power of two, at least 2.
REQ-004 Derived widths SHALL be LINE_W = clog2(LINES) and BLK_W = clog2(BLOCKS).
REQ-005 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 cpu_rd_en  in  1  CPU read request.
REQ-008 cpu_wr_en  in  1  CPU write request.
REQ-009 cpu_line  in  LINE_W  CPU line index.
REQ-010 cpu_block  in  BLK_W  CPU word index within the line.
REQ-011 cpu_wdata  in  DATA_W  CPU write data.
REQ-012 cpu_be  in  DATA_W/8  CPU byte strobes.
REQ-013 rd_data  out  DATA_W  registered read data.
REQ-014 rd_valid  out  1  rd_data updated this cycle.
REQ-015 refill_start  in  1  request a line refill from memory.
REQ-016 refill_line  in  LINE_W  line to refill; sampled with refill_start.
REQ-017 mem_valid  in  1  mem_data carries the next refill word.
REQ-018 mem_data  in  DATA_W  refill word from memory.
REQ-019 refill_busy  out  1  high in FILL and DONE.
REQ-020 refill_block  out  BLK_W  index of the next refill word expected.
REQ-021 refill_done  out  1  one-cycle pulse when a refill completes.

Function
REQ-022 The storage SHALL be LINES*BLOCKS words of DATA_W bits, addressed {line, block}.
REQ-023 The refill FSM SHALL have three states: IDLE, FILL and DONE.
REQ-024 In IDLE, refill_start SHALL latch refill_line, clear the word counter and move to FILL on the next edge.
REQ-025 In FILL, each cycle with mem_valid=1 SHALL write mem_data to {latched line, counter} and increment the counter; cycles with mem_valid=0 SHALL hold state.
REQ-026 In FILL, mem_valid=1 with counter = BLOCKS-1 SHALL write the last word and move to DONE.
REQ-027 In DONE, refill_done SHALL be 1 for exactly that cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-028 refill_start outside IDLE SHALL be ignored; mem_valid outside FILL SHALL be ignored.
REQ-029 In IDLE, cpu_wr_en=1 SHALL write cpu_wdata to {cpu_line, cpu_block} per REQ-040/041.
REQ-030 cpu_wr_en while refill_busy=1 SHALL be dropped with no write.
REQ-031 cpu_rd_en=1 SHALL load rd_data from {cpu_line, cpu_block} at the edge and set rd_valid=1 for the following cycle (1-cycle latency) in every FSM state.
REQ-032 When cpu_rd_en=0, rd_valid SHALL be 0 and rd_data SHALL hold its value.
REQ-033 A read and a write to the same word in one cycle SHALL return the pre-write data.
REQ-034 refill_start with cpu_wr_en in the same IDLE cycle: the CPU write SHALL complete and the refill SHALL start.

Reset
REQ-035 rst_n=0 SHALL immediately force state=IDLE, counter=0, rd_data=0, rd_valid=0 and refill_done=0.
REQ-036 Storage contents SHALL NOT be reset.
REQ-037 Reset during FILL SHALL abort the refill; words already written SHALL remain and refill_done SHALL NOT pulse.

Configuration
REQ-038 The macro CACHE_BYTE_WRITE_EN SHALL select the byte-write feature.
REQ-039 Refill writes SHALL always write the full word.
REQ-040 With CACHE_BYTE_WRITE_EN defined, CPU writes SHALL update only the bytes whose cpu_be bit is 1; cpu_be=0 SHALL write nothing.
REQ-041 Without CACHE_BYTE_WRITE_EN, cpu_be SHALL be ignored and CPU writes SHALL update the full word.

Verification
REQ-042 Refill line 5 with words A0..A3 at one word per cycle -> refill_done pulses once, 1 cycle after the 4th word; reads of {5,0..3} return A0..A3, each 1 cycle after the read request.
REQ-043 Refill with mem_valid gaps (pattern 1,0,0,1,1,0,1) -> refill_block steps 0,1,1,1,2,3,3; done only after the 4th valid word.
REQ-044 CPU write 32'hDEADBEEF to {3,2} while refill_busy=1 -> the word is unchanged; the same write in IDLE -> the read returns 32'hDEADBEEF.
REQ-045 With the byte feature: write 32'h11223344 with cpu_be=4'b1111, then 32'hAABBCCDD with cpu_be=4'b0101 -> the read returns 32'h11BB33DD. Without the feature, the read returns 32'hAABBCCDD.
REQ-046 Assert rst_n=0 after 2 refill words -> state returns to IDLE with refill_busy=0, no refill_done; words 0 and 1 are retained.
REQ-047 Read {7,1} while writing 32'h5 to {7,1} (old value 32'h9) -> rd_data=32'h9; the next read returns 32'h5.
